shift_chain_ctrl: RTL and testbench

Sequencer for the team's serial shift datapath. Accepts a parallel word over a valid/ready handshake and drives it bit-serially onto `so` with a one-cycle `shift_en` strobe per bit for the downstream serial stages. On the same strobes it captures the returning serial bit `si` into a parallel word. It reports each completed transfer with a one-cycle `out_valid` pulse.

---
 rtl/shift_ctrl_pkg.sv | 29 ++
 rtl/shift_tick_gen.sv | 44 ++++
 rtl/shift_chain_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_chain_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial shift chain controller.
//   state_e      : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
//   DefaultWidth : default bits per transfer
//   DefaultDiv   : default clocks per bit
//   clog2()      : ceiling log2, usable in constant expressions
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDiv   = 1;

  // Returns ceil(log2(value)); clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Bit-rate strobe generator for the shift chain controller.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero both counters (start of a new transfer)
//   enable   : count while high (controller in SHIFT)
//   tick     : one-cycle strobe every DIV enabled clocks
//   last     : tick that completes the WIDTH-th bit
module shift_tick_gen
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIV   = DefaultDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic last
);

  localparam int unsigned DivW = (DIV > 1) ? clog2(DIV) : 1;
  localparam int unsigned CntW = clog2(WIDTH + 1);

  logic [DivW-1:0] div_cnt_q;
  logic [CntW-1:0] bit_cnt_q;

  assign tick = enable && (div_cnt_q == DivW'(DIV - 1));
  assign last = tick && (bit_cnt_q == CntW'(WIDTH - 1));

  // Counters only return to zero through rst/clear or the div wrap on a tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end else if (enable) begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Serial shift chain sequencer. Takes a parallel word over valid/ready, drives it
// bit-serially on so with a shift_en strobe per bit, captures si on the same strobes
// and reports the received word with a one-cycle out_valid pulse.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   in_valid, in_ready : parallel input handshake
//   in_data            : word to transmit
//   so                 : registered serial output bit
//   shift_en           : per-bit strobe for downstream stages, si sampled here
//   si                 : serial return bit from the chain end
//   out_valid          : one-cycle completion pulse
//   out_data           : last received word
//   busy               : transfer in progress
module shift_chain_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DIV       = DefaultDiv,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             so,
  output logic             shift_en,
  input  logic             si,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             so_q, so_d;
  logic             accept, tick, last;

  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept    = in_valid && in_ready;
  assign so        = so_q;
  assign shift_en  = tick;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);

  shift_tick_gen #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state_q == StShift),
    .tick   (tick),
    .last   (last)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    out_data_d = out_data_q;
    so_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_d    = in_data;
          rx_d    = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          if (MSB_FIRST) begin
            tx_d = {tx_q[WIDTH-2:0], 1'b0};
            rx_d = {rx_q[WIDTH-2:0], si};
          end else begin
            tx_d = {1'b0, tx_q[WIDTH-1:1]};
            rx_d = {si, rx_q[WIDTH-1:1]};
          end
          if (last) begin
            state_d    = StDone;
            out_data_d = rx_d;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // so is registered: it presents the bit at the head of the next tx word.
    if (state_d == StShift) begin
      so_d = MSB_FIRST ? tx_d[WIDTH-1] : tx_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      out_data_q <= '0;
      so_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      out_data_q <= out_data_d;
      so_q       <= so_d;
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Bench for shift_chain_ctrl: three instances (DIV=1 MSB-first loopback, DIV=3
// MSB-first loopback, DIV=2 LSB-first with si tied high). A scoreboard queue holds
// expected received words; a monitor pops and compares on every out_valid.
module tb_shift_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  int         sel;
  logic       drv_valid;
  logic [7:0] drv_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  logic a_in_valid, a_in_ready, a_so, a_shift_en, a_out_valid, a_busy;
  logic b_in_valid, b_in_ready, b_so, b_shift_en, b_out_valid, b_busy;
  logic c_in_valid, c_in_ready, c_so, c_shift_en, c_out_valid, c_busy;
  logic [7:0] a_out_data, b_out_data, c_out_data;

  assign a_in_valid = drv_valid && (sel == 0);
  assign b_in_valid = drv_valid && (sel == 1);
  assign c_in_valid = drv_valid && (sel == 2);

  shift_chain_ctrl #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(drv_data),
    .so(a_so), .shift_en(a_shift_en), .si(a_so), .out_valid(a_out_valid),
    .out_data(a_out_data), .busy(a_busy)
  );

  shift_chain_ctrl #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(drv_data),
    .so(b_so), .shift_en(b_shift_en), .si(b_so), .out_valid(b_out_valid),
    .out_data(b_out_data), .busy(b_busy)
  );

  shift_chain_ctrl #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(drv_data),
    .so(c_so), .shift_en(c_shift_en), .si(1'b1), .out_valid(c_out_valid),
    .out_data(c_out_data), .busy(c_busy)
  );

  // Observation view of the instance under test.
  logic       m_ready, m_so, m_se, m_ov, m_busy;
  logic [7:0] m_od;
  always_comb begin
    m_ready = a_in_ready; m_so = a_so; m_se = a_shift_en;
    m_ov = a_out_valid; m_busy = a_busy; m_od = a_out_data;
    case (sel)
      1: begin
        m_ready = b_in_ready; m_so = b_so; m_se = b_shift_en;
        m_ov = b_out_valid; m_busy = b_busy; m_od = b_out_data;
      end
      2: begin
        m_ready = c_in_ready; m_so = c_so; m_se = c_shift_en;
        m_ov = c_out_valid; m_busy = c_busy; m_od = c_out_data;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_ov === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid at %0t: got out_data %0h expected no pulse",
                 $time, m_od);
      end else begin
        chk("sb_out_data", 32'(m_od), 32'(sb_q.pop_front()));
      end
    end
  end

  // One full transfer on the selected instance with per-cycle timing checks.
  // Called just after a negedge with the controller idle.
  task automatic xfer(input int div, input bit msb, input logic [7:0] d,
                      input logic [7:0] expo, input bit poke);
    int   total;
    int   k;
    logic exp_so;
    total = 8 * div;
    drv_data  = d;
    drv_valid = 1'b1;
    sb_q.push_back(expo);
    chk("ready_before_accept", 32'(m_ready), 32'd1);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    for (int n = 1; n <= total + 2; n++) begin
      @(negedge clk);
      k = (n - 1) / div;
      exp_so = 1'b0;
      if (n <= total) exp_so = msb ? d[7-k] : d[k];
      chk("so", 32'(m_so), 32'(exp_so));
      chk("shift_en", 32'(m_se), 32'((n <= total) && (n % div == 0)));
      chk("busy", 32'(m_busy), 32'(n <= total + 1));
      chk("in_ready", 32'(m_ready), 32'(n == total + 2));
      chk("out_valid", 32'(m_ov), 32'(n == total + 1));
      if (poke && n == 3) begin
        drv_data  = 8'hEE;
        drv_valid = 1'b1;
      end
      if (poke && n == 4) drv_valid = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 0;
    drv_valid = 1'b0;
    drv_data  = 8'h00;

    // Reset values.
    @(negedge clk);
    chk("rst_in_ready", 32'(m_ready), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_so", 32'(m_so), 32'd0);
    chk("rst_shift_en", 32'(m_se), 32'd0);
    chk("rst_out_valid", 32'(m_ov), 32'd0);
    chk("rst_out_data", 32'(m_od), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(m_ready), 32'd1);
    chk("post_rst_busy", 32'(m_busy), 32'd0);

    // 1: DIV=1 MSB-first loopback.
    xfer(1, 1'b1, 8'hA5, 8'hA5, 1'b0);

    // 4: back-to-back with in_valid held high.
    drv_data  = 8'h12;
    drv_valid = 1'b1;
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h34);
    chk("b2b_ready_before", 32'(m_ready), 32'd1);
    @(posedge clk);
    #1 drv_data = 8'h34;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk("b2b_out_valid", 32'(m_ov), 32'(n == 9 || n == 19));
      chk("b2b_in_ready", 32'(m_ready), 32'(n == 10 || n == 20));
      if (n == 11) drv_valid = 1'b0;
    end

    // 5: reset after 4 strobes of 0xF0.
    drv_data  = 8'hF0;
    drv_valid = 1'b1;
    chk("mid_ready_before", 32'(m_ready), 32'd1);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk("mid_shift_en", 32'(m_se), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(m_busy), 32'd0);
    chk("mid_in_ready", 32'(m_ready), 32'd1);
    chk("mid_so", 32'(m_so), 32'd0);
    chk("mid_shift_en_after", 32'(m_se), 32'd0);
    chk("mid_out_data", 32'(m_od), 32'd0);
    chk("mid_out_valid", 32'(m_ov), 32'd0);
    repeat (3) @(negedge clk);
    xfer(1, 1'b1, 8'h0F, 8'h0F, 1'b0);

    // 6: rst and in_valid on the same edge, then in_valid poked during SHIFT.
    @(posedge clk);
    #1;
    rst       = 1'b1;
    drv_valid = 1'b1;
    drv_data  = 8'h77;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    drv_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid_busy", 32'(m_busy), 32'd0);
    chk("rst_valid_ready", 32'(m_ready), 32'd1);
    xfer(1, 1'b1, 8'h5C, 8'h5C, 1'b1);

    // 2: DIV=3 loopback.
    sel = 1;
    @(negedge clk);
    xfer(3, 1'b1, 8'h3C, 8'h3C, 1'b0);

    // 3: LSB-first, si tied high, DIV=2.
    sel = 2;
    @(negedge clk);
    xfer(2, 1'b0, 8'h01, 8'hFF, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
